cargador_serial: RTL and testbench

Bit-serial front end for the right-to-left word comparator. Receives two synchronized serial streams, LSB first, and assembles them into parallel words `wordA`/`wordB`. Presents both words with a valid/ready handshake and holds them stable so the downstream `Comparador` output `z` (1 when A ≤ B) is valid for the whole transfer. Flags framing and overrun errors.

---
 rtl/cargador_pkg.sv | 11 +
 rtl/registro_serie.sv | 35 +++
 rtl/cargador_serial.sv | 164 ++++++++++++++++
 tb/tb_cargador_serial.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cargador_pkg.sv
// Shared definitions for the serial word loader and the comparator bench.
// Holds the FSM encoding and the default word width.
package cargador_pkg;

    localparam int unsigned WIDTH_DEF = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

endpackage

// File: rtl/registro_serie.sv
// WIDTH-bit shadow register with indexed single-bit write and synchronous clear.
// Exposes its next value so the loader can publish a frame including its final bit.
module registro_serie #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] d
);

    // Clear is applied first, so clr & we leaves only the freshly written bit.
    always_comb begin
        d = clr ? '0 : q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (we && idx == IDX_W'(i)) begin
                d[i] = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/cargador_serial.sv
// Bit-serial front end: assembles two LSB-first streams into parallel words
// and presents them with a valid/ready handshake, flagging framing and overrun errors.
module cargador_serial
    import cargador_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serA,
    input  logic             serB,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             out_ready,
    output logic [WIDTH-1:0] wordA,
    output logic [WIDTH-1:0] wordB,
    output logic             word_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             sh_clr;
    logic             sh_we;
    logic [CW-1:0]    sh_idx;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;

    registro_serie #(.WIDTH(WIDTH), .IDX_W(CW)) u_reg_a (
        .clk   (clk),
        .reset (reset),
        .clr   (sh_clr),
        .we    (sh_we),
        .idx   (sh_idx),
        .din   (serA),
        .q     (sh_a_q),
        .d     (sh_a_d)
    );

    registro_serie #(.WIDTH(WIDTH), .IDX_W(CW)) u_reg_b (
        .clk   (clk),
        .reset (reset),
        .clr   (sh_clr),
        .we    (sh_we),
        .idx   (sh_idx),
        .din   (serB),
        .q     (sh_b_q),
        .d     (sh_b_d)
    );

    // Every sof that is accepted clears the shadow and writes bit 0.
    always_comb begin
        sh_clr = 1'b0;
        sh_we  = 1'b0;
        sh_idx = cnt;
        case (state)
            IDLE: begin
                if (bit_valid && sof) begin
                    sh_clr = 1'b1;
                    sh_we  = 1'b1;
                    sh_idx = '0;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    sh_clr = sof;
                    sh_we  = 1'b1;
                    sh_idx = sof ? '0 : cnt;
                end
            end
            HOLD: begin
                if (out_ready && bit_valid && sof) begin
                    sh_clr = 1'b1;
                    sh_we  = 1'b1;
                    sh_idx = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wordA      <= '0;
            wordB      <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_valid) begin
                        if (!sof) begin
                            frame_err <= 1'b1;
                        end else if (WIDTH == 1) begin
                            wordA      <= sh_a_d;
                            wordB      <= sh_b_d;
                            word_valid <= 1'b1;
                            cnt        <= '0;
                            state      <= HOLD;
                        end else begin
                            cnt   <= CW'(1);
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        if (sof) begin
                            frame_err <= 1'b1;
                            cnt       <= CW'(1);
                        end else if (cnt == LAST) begin
                            wordA      <= sh_a_d;
                            wordB      <= sh_b_d;
                            word_valid <= 1'b1;
                            cnt        <= '0;
                            state      <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        word_valid <= 1'b0;
                        state      <= IDLE;
                        if (bit_valid && !sof) begin
                            frame_err <= 1'b1;
                        end else if (bit_valid && sof) begin
                            // A one-bit frame completes on its sof beat.
                            if (WIDTH == 1) begin
                                wordA      <= sh_a_d;
                                wordB      <= sh_b_d;
                                word_valid <= 1'b1;
                                state      <= HOLD;
                            end else begin
                                cnt   <= CW'(1);
                                state <= SHIFT;
                            end
                        end
                    end else if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_cargador_serial.sv
// Self-checking bench for cargador_serial (WIDTH = 3): directed scenarios plus
// random traffic, compared every cycle against a queue-based frame model.
module tb_cargador_serial;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         serA, serB, bit_valid, sof, out_ready;
    logic [W-1:0] wordA, wordB;
    logic         word_valid, busy, frame_err, overrun;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    cargador_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serA       (serA),
        .serB       (serB),
        .bit_valid  (bit_valid),
        .sof        (sof),
        .out_ready  (out_ready),
        .wordA      (wordA),
        .wordB      (wordB),
        .word_valid (word_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference: a frame is a list of received bit pairs; a held pair blocks new bits.
    bit           qa[$];
    bit           qb[$];
    logic [W-1:0] e_a, e_b;
    logic         e_valid, e_ferr, e_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_step(input logic rst, input logic bv, input logic s,
                              input logic a, input logic b, input logic rdy);
        logic take;
        if (rst) begin
            qa.delete(); qb.delete();
            e_a = '0; e_b = '0; e_valid = 0; e_ferr = 0; e_ovr = 0;
        end else begin
            e_ferr = 0;
            e_ovr  = 0;
            take   = bv;
            if (e_valid) begin
                if (rdy) begin
                    e_valid = 0;
                end else begin
                    take  = 0;
                    e_ovr = bv;
                end
            end
            if (take) begin
                if (s) begin
                    if (qa.size() != 0) e_ferr = 1;
                    qa.delete(); qb.delete();
                    qa.push_back(a); qb.push_back(b);
                end else if (qa.size() == 0) begin
                    e_ferr = 1;
                end else begin
                    qa.push_back(a); qb.push_back(b);
                end
                if (qa.size() == W) begin
                    e_a = '0; e_b = '0;
                    for (int k = 0; k < W; k++) begin
                        if (qa[k]) e_a = e_a + (W'(1) << k);
                        if (qb[k]) e_b = e_b + (W'(1) << k);
                    end
                    e_valid = 1;
                    qa.delete(); qb.delete();
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic bv, input logic s,
                        input logic a, input logic b, input logic rdy);
        reset = rst; bit_valid = bv; sof = s; serA = a; serB = b; out_ready = rdy;
        model_step(rst, bv, s, a, b, rdy);
        @(posedge clk);
        #1;
        check("wordA",      32'(wordA),      32'(e_a));
        check("wordB",      32'(wordB),      32'(e_b));
        check("word_valid", 32'(word_valid), 32'(e_valid));
        check("busy",       32'(busy),       32'(qa.size() != 0));
        check("frame_err",  32'(frame_err),  32'(e_ferr));
        check("overrun",    32'(overrun),    32'(e_ovr));
    endtask

    task automatic idle_cycle(input logic rdy);
        step(0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        reset = 1; serA = 0; serB = 0; bit_valid = 0; sof = 0; out_ready = 0;
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        check("rst_state", {wordA, wordB, word_valid, busy, frame_err, overrun}, '0);

        // Basic frame
        step(0, 1, 1, 0, 1, 1);
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        check("basic_A", 32'(wordA), 32'(3'b110));
        check("basic_B", 32'(wordB), 32'(3'b001));
        check("basic_v", 32'(word_valid), 1);
        check("basic_z", 32'(wordA <= wordB), 0);
        idle_cycle(1);
        check("basic_v_drop", 32'(word_valid), 0);

        // Backpressure with one stray bit during the wait
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle_cycle(0);
        step(0, 1, 0, 1, 1, 0);
        check("bp_overrun", 32'(overrun), 1);
        idle_cycle(0);
        idle_cycle(0);
        check("bp_hold_v", 32'(word_valid), 1);
        check("bp_hold_AB", 32'({wordA, wordB}), 32'({3'b000, 3'b001}));
        check("bp_z", 32'(wordA <= wordB), 1);
        idle_cycle(1);
        check("bp_release", 32'(word_valid), 0);

        // Re-sync on beat 2
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 0, 1, 1, 1);
        step(0, 1, 1, 0, 1, 1);
        check("resync_ferr", 32'(frame_err), 1);
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        check("resync_AB", 32'({wordA, wordB}), 32'({3'b010, 3'b001}));

        // Back-to-back frames, out_ready high
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        check("b2b_1", 32'({word_valid, wordA, wordB}), 32'({1'b1, 3'b111, 3'b001}));
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        check("b2b_2", 32'({word_valid, wordA, wordB}), 32'({1'b1, 3'b000, 3'b000}));
        idle_cycle(1);

        // Stray bit in IDLE, then reset mid-frame
        step(0, 1, 0, 1, 1, 1);
        check("stray_ferr", 32'(frame_err), 1);
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 1);
        check("midrst", {wordA, wordB, word_valid, busy, frame_err, overrun}, '0);
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 1, 1, 1);
        check("after_rst_AB", 32'({wordA, wordB}), 32'({3'b101, 3'b110}));

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(99) == 0),
                 ($urandom_range(9) < 7),
                 ($urandom_range(9) < 3),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(9) < 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
